melody_sequencer: RTL and testbench

Plays a programmable melody by sequencing the sine/clkgen/DAC tone datapath. It holds a small note table (pitch divider value + duration), steps through it on sample-rate ticks and drives the sine clkgen `maxval` together with a gate. Between notes it can insert an optional rest. It sits between the fs clkgen (tick source) and the pitch clkgen/sine generator, replacing hard-coded melody arrays with a writable table and start/stop/loop control.

---
 rtl/melody_sequencer_if.sv | 33 +++
 rtl/melody_sequencer.sv | 137 +++++++++++++
 tb/tb_melody_sequencer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/melody_sequencer_if.sv
// Control, table-write and tone-output bundle of the melody sequencer.
// The sequencer takes the slave modport; the driving side takes master.
interface melody_sequencer_if #(
  parameter int unsigned AW      = 5,
  parameter int unsigned PITCH_W = 5,
  parameter int unsigned DUR_W   = 13
);
  logic               fs_tick;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [PITCH_W-1:0] wr_pitch;
  logic [DUR_W-1:0]   wr_dur;
  logic [AW-1:0]      last_idx;
  logic               start;
  logic               stop;
  logic               loop;
  logic [PITCH_W-1:0] pitch_out;
  logic               note_on;
  logic               note_start;
  logic [AW-1:0]      cur_idx;
  logic               busy;
  logic               done;

  modport master (
    output fs_tick, wr_en, wr_addr, wr_pitch, wr_dur, last_idx, start, stop, loop,
    input  pitch_out, note_on, note_start, cur_idx, busy, done
  );

  modport slave (
    input  fs_tick, wr_en, wr_addr, wr_pitch, wr_dur, last_idx, start, stop, loop,
    output pitch_out, note_on, note_start, cur_idx, busy, done
  );
endinterface

// File: rtl/melody_sequencer.sv
// Steps a writable note table on fs ticks, driving the sine clkgen maxval and
// a gate, with optional silent gap between notes and start/stop/loop control.
module melody_sequencer #(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned AW        = 5,
  parameter int unsigned PITCH_W   = 5,
  parameter int unsigned DUR_W     = 13,
  parameter int unsigned GAP_TICKS = 0
) (
  input logic               clk,
  input logic               reset,
  melody_sequencer_if.slave bus
);

  localparam int unsigned GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_TICKS == 0) ? '0 : GAP_W'(GAP_TICKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY, S_REST} state_t;

  state_t                   r_state;
  logic [AW-1:0]            r_idx;
  logic [AW-1:0]            r_last;
  logic [DUR_W-1:0]         r_dur_cnt;
  logic [GAP_W-1:0]         r_gap_cnt;
  logic [PITCH_W-1:0]       r_pitch_out;
  logic                     r_note_on;
  logic                     r_note_start;
  logic                     r_busy;
  logic                     r_done;
  logic [PITCH_W+DUR_W-1:0] r_table [DEPTH];

  logic [PITCH_W+DUR_W-1:0] w_entry;
  logic [PITCH_W-1:0]       w_pitch;
  logic [DUR_W-1:0]         w_dur;
  logic                     w_note_end;
  logic                     w_gap_end;
  logic                     w_advance;

  // Table has no reset so a melody survives a reset pulse.
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      r_table[bus.wr_addr] <= {bus.wr_pitch, bus.wr_dur};
    end
  end

  always_comb begin
    w_entry    = r_table[r_idx];
    w_pitch    = w_entry[PITCH_W+DUR_W-1:DUR_W];
    w_dur      = w_entry[DUR_W-1:0];
    w_note_end = (r_state == S_PLAY) && bus.fs_tick && (r_dur_cnt == '0);
    w_gap_end  = (r_state == S_REST) && bus.fs_tick && (r_gap_cnt == '0);
    w_advance  = w_gap_end || (w_note_end && (GAP_TICKS == 0));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_last       <= '0;
      r_dur_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_pitch_out  <= '0;
      r_note_on    <= 1'b0;
      r_note_start <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_note_start <= 1'b0;
      r_done       <= 1'b0;
      if (bus.stop) begin
        r_state     <= S_IDLE;
        r_idx       <= '0;
        r_pitch_out <= '0;
        r_note_on   <= 1'b0;
        r_busy      <= 1'b0;
      end else if (w_advance) begin
        // note_on/pitch_out hold through FETCH; only finishing clears them
        if (r_idx != r_last) begin
          r_idx   <= r_idx + AW'(1);
          r_state <= S_FETCH;
        end else if (bus.loop) begin
          r_idx   <= '0;
          r_state <= S_FETCH;
        end else begin
          r_state     <= S_IDLE;
          r_pitch_out <= '0;
          r_note_on   <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b1;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              r_last  <= bus.last_idx;
              r_idx   <= '0;
              r_busy  <= 1'b1;
              r_state <= S_FETCH;
            end
          end
          S_FETCH: begin
            r_pitch_out  <= w_pitch;
            r_note_on    <= (w_pitch != '0);
            r_note_start <= 1'b1;
            r_dur_cnt    <= (w_dur == '0) ? '0 : w_dur - DUR_W'(1);
            r_state      <= S_PLAY;
          end
          S_PLAY: begin
            if (bus.fs_tick) begin
              if (r_dur_cnt == '0) begin
                r_gap_cnt <= GAP_LOAD;
                r_note_on <= 1'b0;
                r_state   <= S_REST;
              end else begin
                r_dur_cnt <= r_dur_cnt - DUR_W'(1);
              end
            end
          end
          S_REST: begin
            if (bus.fs_tick) begin
              r_gap_cnt <= r_gap_cnt - GAP_W'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.pitch_out  = r_pitch_out;
  assign bus.note_on    = r_note_on;
  assign bus.note_start = r_note_start;
  assign bus.cur_idx    = r_idx;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: legato instance u0 (GAP_TICKS=0) and gapped
// instance u2 (GAP_TICKS=2) share all inputs; outputs are checked per instance.
module tb_melody_sequencer;
  localparam int unsigned AW = 5;
  localparam int unsigned PW = 5;
  localparam int unsigned DW = 13;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          fs_tick, wr_en, start, stop, loop;
  logic [AW-1:0] wr_addr, last_idx;
  logic [PW-1:0] wr_pitch;
  logic [DW-1:0] wr_dur;

  melody_sequencer_if #(.AW(AW), .PITCH_W(PW), .DUR_W(DW)) b0 ();
  melody_sequencer_if #(.AW(AW), .PITCH_W(PW), .DUR_W(DW)) b2 ();

  assign b0.fs_tick = fs_tick;  assign b2.fs_tick = fs_tick;
  assign b0.wr_en   = wr_en;    assign b2.wr_en   = wr_en;
  assign b0.wr_addr = wr_addr;  assign b2.wr_addr = wr_addr;
  assign b0.wr_pitch = wr_pitch; assign b2.wr_pitch = wr_pitch;
  assign b0.wr_dur  = wr_dur;   assign b2.wr_dur  = wr_dur;
  assign b0.last_idx = last_idx; assign b2.last_idx = last_idx;
  assign b0.start   = start;    assign b2.start   = start;
  assign b0.stop    = stop;     assign b2.stop    = stop;
  assign b0.loop    = loop;     assign b2.loop    = loop;

  melody_sequencer #(.DEPTH(32), .AW(AW), .PITCH_W(PW), .DUR_W(DW), .GAP_TICKS(0)) u0 (
    .clk(clk), .reset(reset), .bus(b0.slave));
  melody_sequencer #(.DEPTH(32), .AW(AW), .PITCH_W(PW), .DUR_W(DW), .GAP_TICKS(2)) u2 (
    .clk(clk), .reset(reset), .bus(b2.slave));

  // Output monitor selects one instance.
  bit            sel;
  logic [PW-1:0] m_pitch;
  logic          m_on, m_ns, m_busy, m_done;
  logic [AW-1:0] m_idx;
  always_comb begin
    m_pitch = sel ? b2.pitch_out  : b0.pitch_out;
    m_on    = sel ? b2.note_on    : b0.note_on;
    m_ns    = sel ? b2.note_start : b0.note_start;
    m_idx   = sel ? b2.cur_idx    : b0.cur_idx;
    m_busy  = sel ? b2.busy       : b0.busy;
    m_done  = sel ? b2.done       : b0.done;
  end

  int n_chk = 0;
  int n_err = 0;
  int cnt_on [32];
  int cnt_off[32];
  int ns_cnt, done_cnt;
  bit wrapped;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input int a, input int p, input int d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_pitch = PW'(p); wr_dur = DW'(d);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Runs n cycles with a tick every p cycles (none on cycle 0), optional
  // one-cycle start on cycle 0; tallies ticks by the pitch/gate showing then.
  task automatic run(input int n, input int p, input bit do_start);
    logic [AW-1:0] prev_idx;
    foreach (cnt_on[i]) begin cnt_on[i] = 0; cnt_off[i] = 0; end
    ns_cnt = 0; done_cnt = 0; wrapped = 1'b0;
    for (int c = 0; c < n; c++) begin
      start   = do_start && (c == 0);
      fs_tick = (c > 0) && ((c % p) == p - 1);
      if (fs_tick) begin
        if (m_on) cnt_on[m_pitch]++;
        else      cnt_off[m_pitch]++;
      end
      prev_idx = m_idx;
      step();
      if (m_ns)   ns_cnt++;
      if (m_done) done_cnt++;
      if (m_busy && prev_idx == AW'(1) && m_idx == '0) wrapped = 1'b1;
    end
    start = 1'b0; fs_tick = 1'b0;
  endtask

  typedef struct {
    bit start, stop, loop, tick;
    int pitch;
    bit on, ns;
    int idx;
    bit busy, done;
  } vec_t;

  vec_t vt[23];

  initial begin
    logic [15:0] exp_v, act_v;
    vt = '{
      '{1,0,0,0,  0,0,0,0,1,0},
      '{0,0,0,1, 18,1,1,0,1,0},
      '{0,0,0,0, 18,1,0,0,1,0},
      '{0,0,0,1, 18,1,0,0,1,0},
      '{0,0,0,1, 18,1,0,1,1,0},
      '{0,0,0,0,  0,0,1,1,1,0},
      '{0,0,0,1,  0,0,0,2,1,0},
      '{0,0,0,0,  7,1,1,2,1,0},
      '{0,0,0,0,  7,1,0,2,1,0},
      '{0,0,0,1,  0,0,0,2,0,1},
      '{0,0,0,0,  0,0,0,2,0,0},
      '{1,1,0,0,  0,0,0,0,0,0},
      '{1,0,1,0,  0,0,0,0,1,0},
      '{1,0,1,0, 18,1,1,0,1,0},
      '{0,0,1,1, 18,1,0,0,1,0},
      '{0,0,1,1, 18,1,0,1,1,0},
      '{0,0,1,0,  0,0,1,1,1,0},
      '{0,0,1,1,  0,0,0,2,1,0},
      '{0,0,1,0,  7,1,1,2,1,0},
      '{0,0,1,1,  7,1,0,0,1,0},
      '{0,0,0,0, 18,1,1,0,1,0},
      '{0,1,0,1,  0,0,0,0,0,0},
      '{0,0,0,0,  0,0,0,0,0,0}
    };

    sel = 1'b0;
    fs_tick = 0; wr_en = 0; start = 0; stop = 0; loop = 0;
    wr_addr = '0; wr_pitch = '0; wr_dur = '0; last_idx = '0;
    reset = 1'b0;
    #12;
    chk("reset_u0", {b0.pitch_out, b0.note_on, b0.note_start, b0.cur_idx, b0.busy, b0.done}, 0);
    chk("reset_u2", {b2.pitch_out, b2.note_on, b2.note_start, b2.cur_idx, b2.busy, b2.done}, 0);
    @(negedge clk); reset = 1'b1;
    step();

    // Cycle-exact vectors on u0
    wr(0, 18, 2); wr(1, 0, 1); wr(2, 7, 0);
    last_idx = AW'(2);
    for (int i = 0; i < 23; i++) begin
      start = vt[i].start; stop = vt[i].stop; loop = vt[i].loop; fs_tick = vt[i].tick;
      step();
      exp_v = {2'b0, PW'(vt[i].pitch), vt[i].on, vt[i].ns, AW'(vt[i].idx), vt[i].busy, vt[i].done};
      act_v = {2'b0, b0.pitch_out, b0.note_on, b0.note_start, b0.cur_idx, b0.busy, b0.done};
      chk($sformatf("vec%0d", i), 32'(act_v), 32'(exp_v));
    end
    start = 0; stop = 0; loop = 0; fs_tick = 0;

    // Basic playback at 125-clk tick spacing
    wr(0, 18, 4); wr(1, 13, 2); last_idx = AW'(1);
    run(900, 125, 1'b1);
    chk("basic_18_ticks", cnt_on[18], 4);
    chk("basic_13_ticks", cnt_on[13], 2);
    chk("basic_note_start", ns_cnt, 2);
    chk("basic_done", done_cnt, 1);
    chk("basic_busy_end", m_busy, 0);

    // Loop with a rest entry
    wr(1, 0, 2); loop = 1'b1;
    run(41, 5, 1'b1);
    chk("loop_18_ticks", cnt_on[18], 6);
    chk("loop_rest_ticks", cnt_off[0], 2);
    chk("loop_wrap", wrapped, 1);
    chk("loop_no_done", done_cnt, 0);
    chk("loop_note_start", ns_cnt, 3);
    stop = 1'b1; step(); stop = 1'b0; loop = 1'b0;

    // Gap instance with zero-duration first note
    sel = 1'b1;
    wr(0, 18, 0); wr(1, 13, 2);
    run(40, 5, 1'b1);
    chk("gap_18_on", cnt_on[18], 1);
    chk("gap_18_off", cnt_off[18], 2);
    chk("gap_13_on", cnt_on[13], 2);
    chk("gap_13_off", cnt_off[13], 2);
    chk("gap_note_start", ns_cnt, 2);
    chk("gap_done", done_cnt, 1);
    sel = 1'b0;

    // Stop mid-note together with tick and start
    wr(0, 18, 4);
    run(23, 5, 1'b1);
    chk("stop_pre_idx", m_idx, 1);
    chk("stop_pre_pitch", m_pitch, 13);
    stop = 1'b1; fs_tick = 1'b1; start = 1'b1;
    step();
    stop = 1'b0; fs_tick = 1'b0; start = 1'b0;
    chk("stop_pitch", m_pitch, 0);
    chk("stop_on", m_on, 0);
    chk("stop_idx", m_idx, 0);
    chk("stop_busy", m_busy, 0);
    chk("stop_done", m_done, 0);
    step();
    chk("stop_done_after", m_done, 0);
    chk("stop_busy_after", m_busy, 0);

    // Asynchronous reset between edges, then replay from retained table
    run(8, 5, 1'b1);
    chk("areset_pre_on", m_on, 1);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("areset_outputs", {b0.pitch_out, b0.note_on, b0.note_start, b0.cur_idx, b0.busy, b0.done}, 0);
    @(posedge clk); #3;
    reset = 1'b1;
    step();
    run(40, 5, 1'b1);
    chk("replay_18_ticks", cnt_on[18], 4);
    chk("replay_13_ticks", cnt_on[13], 2);
    chk("replay_done", done_cnt, 1);

    // Overwrite the playing entry
    loop = 1'b1;
    run(3, 5, 1'b1);
    wr(0, 21, 4);
    chk("wr_cur_pitch", m_pitch, 18);
    run(36, 5, 1'b0);
    chk("wr_18_ticks", cnt_on[18], 4);
    chk("wr_13_ticks", cnt_on[13], 2);
    chk("wr_21_ticks", cnt_on[21], 1);
    stop = 1'b1; step(); stop = 1'b0; loop = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
